dtage_update: RTL and testbench

DTAGE_UPDATE -- requirements
Module: dtage_update

---
 rtl/dtage_pkg.sv | 33 +++
 rtl/dtage_hash.sv | 25 ++
 rtl/dtage_update.sv | 225 ++++++++++++++++++++++
 tb/tb_dtage_update.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtage_pkg.sv
// dtage_pkg: shared widths, table line layout and update FSM states for the
// dual-table TAGE-style target predictor update engine.
//   TAG_W      - partial tag width stored per line
//   PRED_W     - predicted target width stored per line
//   IDX_W      - table index width (8 lines per table)
//   NUM_TABLES - number of tagged tables (table 1 has the longer history)
package dtage_pkg;

   localparam int TAG_W      = 6;
   localparam int PRED_W     = 16;
   localparam int IDX_W      = 3;
   localparam int NUM_TABLES = 2;

   // One tagged-table entry.
   typedef struct packed {
      logic [PRED_W-1:0] pred;
      logic [TAG_W-1:0]  tag;
   } line_t;

   // IDLE: waiting for a resolved branch
   // RD1 : read table 1        RD0: read table 0, table-1 data returns
   // CHK : table-0 data returns, decide writes
   // WRA : first (or only) write   WRB: table-1 allocation after a table-0 hit
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD1  = 3'd1,
      RD0  = 3'd2,
      CHK  = 3'd3,
      WRA  = 3'd4,
      WRB  = 3'd5
   } state_t;

endpackage

// File: rtl/dtage_hash.sv
// dtage_hash: folds a branch PC with one table's history into that table's
// index and partial tag. Purely combinational; one instance per table.
//   pc    - branch PC
//   h     - history for this table
//   index - pc[2:0] ^ h[2:0]
//   tag   - low TAG_W bits of pc ^ h
module dtage_hash
   import dtage_pkg::*;
(
   input  logic [PRED_W-1:0] pc,
   input  logic [PRED_W-1:0] h,
   output logic [IDX_W-1:0]  index,
   output logic [TAG_W-1:0]  tag
);

   logic [PRED_W-1:0] folded;
   logic              unused_hi;

   assign folded    = pc ^ h;
   assign index     = folded[IDX_W-1:0];
   assign tag       = folded[TAG_W-1:0];
   // Upper fold bits do not participate in index or tag.
   assign unused_hi = ^folded[PRED_W-1:TAG_W];

endmodule

// File: rtl/dtage_update.sv
// dtage_update: update engine for a two-table tagged target predictor.
// Accepts one resolved branch at a time, reads both tagged tables through a
// shared read port, decides which entries to correct or allocate, and issues
// up to two writes through a single write port.
//
// Handshake: a branch transfers on a rising edge where upd_valid and
// upd_ready are both high; upd_ready is high only while IDLE, and the
// producer must hold its payload stable while upd_valid is high and
// upd_ready is low.
//
// Ports:
//   clk, rst                      - rising-edge clock, async active-high reset
//   upd_valid/upd_ready           - resolved-branch handshake
//   upd_pc, upd_h, upd_target     - branch PC, per-table history, real target
//   rd_en, rd_table, rd_index     - table read request
//   rd_vld, rd_tag, rd_pred       - read response, one cycle after rd_en
//   wr_en, wr_table, wr_index,
//   wr_tag, wr_pred               - table write port
//   upd_done                      - one-cycle pulse in the final active cycle
//   busy                          - update in flight
//   alloc_cnt                     - saturating count of allocation writes
module dtage_update #(
   parameter int NUM_TABLES = 2,   // only 2 is supported
   parameter int CNT_W      = 16
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         upd_valid,
   output logic                                         upd_ready,
   input  logic [dtage_pkg::PRED_W-1:0]                 upd_pc,
   input  logic [NUM_TABLES-1:0][dtage_pkg::PRED_W-1:0] upd_h,
   input  logic [dtage_pkg::PRED_W-1:0]                 upd_target,
   output logic                                         rd_en,
   output logic                                         rd_table,
   output logic [dtage_pkg::IDX_W-1:0]                  rd_index,
   input  logic                                         rd_vld,
   input  logic [dtage_pkg::TAG_W-1:0]                  rd_tag,
   input  logic [dtage_pkg::PRED_W-1:0]                 rd_pred,
   output logic                                         wr_en,
   output logic                                         wr_table,
   output logic [dtage_pkg::IDX_W-1:0]                  wr_index,
   output logic [dtage_pkg::TAG_W-1:0]                  wr_tag,
   output logic [dtage_pkg::PRED_W-1:0]                 wr_pred,
   output logic                                         upd_done,
   output logic                                         busy,
   output logic [CNT_W-1:0]                             alloc_cnt
);

   import dtage_pkg::*;

   state_t            state;

   logic [IDX_W-1:0]  idx_c [NUM_TABLES];
   logic [TAG_W-1:0]  tag_c [NUM_TABLES];
   logic [IDX_W-1:0]  idx_q [NUM_TABLES];
   logic [TAG_W-1:0]  tag_q [NUM_TABLES];
   logic [PRED_W-1:0] target_q;

   // Table-1 response captured in RD0.
   line_t             line1_q;
   logic              line1_vld;

   // Second write still owed after WRA, and allocation flag of the write on
   // the port this cycle.
   logic              pend_b;
   logic              wr_alloc;

   // Decision terms, meaningful in CHK only.
   logic              hit0;
   logic              hit1;
   logic              need_write;
   logic              two_writes;
   logic              a_table;
   logic              a_alloc;

   for (genvar i = 0; i < NUM_TABLES; i++) begin : g_hash
      dtage_hash u_hash (
         .pc    (upd_pc),
         .h     (upd_h[i]),
         .index (idx_c[i]),
         .tag   (tag_c[i])
      );
   end

   // The table-0 response is consumed directly in CHK: it arrives in the
   // same cycle the decision is made, so it is never registered.
   always_comb begin
      hit1       = line1_vld && (line1_q.tag == tag_q[1]);
      hit0       = rd_vld && (rd_tag == tag_q[0]);
      need_write = 1'b0;
      two_writes = 1'b0;
      a_table    = 1'b0;
      a_alloc    = 1'b0;
      if (hit1) begin
         if (line1_q.pred != target_q) begin
            need_write = 1'b1;
            a_table    = 1'b1;
         end
      end else if (hit0) begin
         // Correct table 0, then allocate the longer-history table.
         if (rd_pred != target_q) begin
            need_write = 1'b1;
            two_writes = 1'b1;
         end
      end else if (target_q != '0) begin
         // Base prediction is 0; only allocate when it was wrong.
         need_write = 1'b1;
         a_alloc    = 1'b1;
      end
   end

   assign upd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign upd_done  = ((state == CHK) && !need_write) ||
                      ((state == WRA) && !pend_b) ||
                      (state == WRB);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rd_en     <= 1'b0;
         rd_table  <= 1'b0;
         rd_index  <= '0;
         wr_en     <= 1'b0;
         wr_table  <= 1'b0;
         wr_index  <= '0;
         wr_tag    <= '0;
         wr_pred   <= '0;
         wr_alloc  <= 1'b0;
         pend_b    <= 1'b0;
         target_q  <= '0;
         line1_q   <= '0;
         line1_vld <= 1'b0;
         alloc_cnt <= '0;
         for (int i = 0; i < NUM_TABLES; i++) begin
            idx_q[i] <= '0;
            tag_q[i] <= '0;
         end
      end else begin
         // Count an allocation in the cycle its write is on the port.
         if (wr_en && wr_alloc && (alloc_cnt != '1)) begin
            alloc_cnt <= alloc_cnt + 1'b1;
         end

         unique case (state)
            IDLE: begin
               if (upd_valid) begin
                  for (int i = 0; i < NUM_TABLES; i++) begin
                     idx_q[i] <= idx_c[i];
                     tag_q[i] <= tag_c[i];
                  end
                  target_q <= upd_target;
                  rd_en    <= 1'b1;
                  rd_table <= 1'b1;
                  rd_index <= idx_c[1];
                  state    <= RD1;
               end
            end

            RD1: begin
               rd_table <= 1'b0;
               rd_index <= idx_q[0];
               state    <= RD0;
            end

            RD0: begin
               rd_en        <= 1'b0;
               rd_table     <= 1'b0;
               rd_index     <= '0;
               line1_vld    <= rd_vld;
               line1_q.pred <= rd_pred;
               line1_q.tag  <= rd_tag;
               state        <= CHK;
            end

            CHK: begin
               if (need_write) begin
                  wr_en    <= 1'b1;
                  wr_table <= a_table;
                  wr_index <= idx_q[a_table];
                  wr_tag   <= tag_q[a_table];
                  wr_pred  <= target_q;
                  wr_alloc <= a_alloc;
                  pend_b   <= two_writes;
                  state    <= WRA;
               end else begin
                  state <= IDLE;
               end
            end

            WRA: begin
               if (pend_b) begin
                  wr_table <= 1'b1;
                  wr_index <= idx_q[1];
                  wr_tag   <= tag_q[1];
                  wr_alloc <= 1'b1;
                  pend_b   <= 1'b0;
                  state    <= WRB;
               end else begin
                  wr_en    <= 1'b0;
                  wr_table <= 1'b0;
                  wr_index <= '0;
                  wr_tag   <= '0;
                  wr_pred  <= '0;
                  wr_alloc <= 1'b0;
                  state    <= IDLE;
               end
            end

            WRB: begin
               wr_en    <= 1'b0;
               wr_table <= 1'b0;
               wr_index <= '0;
               wr_tag   <= '0;
               wr_pred  <= '0;
               wr_alloc <= 1'b0;
               state    <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dtage_update.sv
// tb_dtage_update: directed and randomised checks of the dtage_update engine.
// A table responder answers reads one cycle after rd_en from per-table
// settings; a monitor compares every read and write against expected queues.
module tb_dtage_update;

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              upd_valid = 1'b0;
   logic              upd_ready;
   logic [15:0]       upd_pc = '0;
   logic [1:0][15:0]  upd_h = '0;
   logic [15:0]       upd_target = '0;
   logic              rd_en;
   logic              rd_table;
   logic [2:0]        rd_index;
   logic              rd_vld = 1'b0;
   logic [5:0]        rd_tag = '0;
   logic [15:0]       rd_pred = '0;
   logic              wr_en;
   logic              wr_table;
   logic [2:0]        wr_index;
   logic [5:0]        wr_tag;
   logic [15:0]       wr_pred;
   logic              upd_done;
   logic              busy;
   logic [CNT_W-1:0]  alloc_cnt;

   // Per-table responder settings.
   logic              cfg_vld  [2];
   logic [5:0]        cfg_tag  [2];
   logic [15:0]       cfg_pred [2];

   // Scoreboard: {table, index, tag, pred} writes and {table, index} reads.
   logic [25:0]       exp_q[$];
   logic [3:0]        exp_rd_q[$];
   logic [CNT_W-1:0]  exp_alloc = '0;

   int total = 0;
   int bad   = 0;

   dtage_update #(.NUM_TABLES(2), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .upd_valid  (upd_valid),
      .upd_ready  (upd_ready),
      .upd_pc     (upd_pc),
      .upd_h      (upd_h),
      .upd_target (upd_target),
      .rd_en      (rd_en),
      .rd_table   (rd_table),
      .rd_index   (rd_index),
      .rd_vld     (rd_vld),
      .rd_tag     (rd_tag),
      .rd_pred    (rd_pred),
      .wr_en      (wr_en),
      .wr_table   (wr_table),
      .wr_index   (wr_index),
      .wr_tag     (wr_tag),
      .wr_pred    (wr_pred),
      .upd_done   (upd_done),
      .busy       (busy),
      .alloc_cnt  (alloc_cnt)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- table responder ----------------
   always @(posedge clk) begin
      if (rd_en) begin
         rd_vld  <= cfg_vld[rd_table];
         rd_tag  <= cfg_tag[rd_table];
         rd_pred <= cfg_pred[rd_table];
      end else begin
         rd_vld  <= 1'b0;
         rd_tag  <= '0;
         rd_pred <= '0;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst) begin
         total++;
         if (rd_en && wr_en) begin
            bad++;
            $display("FAIL rd_wr_exclusive: rd_en=%0b wr_en=%0b required not both", rd_en, wr_en);
         end
         if (rd_en) begin
            total++;
            if (exp_rd_q.size() == 0) begin
               bad++;
               $display("FAIL read_unexpected: got tbl=%0d idx=%0d required no read", rd_table, rd_index);
            end else begin
               logic [3:0] er;
               er = exp_rd_q.pop_front();
               if ({rd_table, rd_index} !== er) begin
                  bad++;
                  $display("FAIL read_addr: got tbl=%0d idx=%0d required tbl=%0d idx=%0d",
                           rd_table, rd_index, er[3], er[2:0]);
               end
            end
         end
         if (wr_en) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL write_unexpected: got tbl=%0d idx=%0d tag=%h pred=%h required no write",
                        wr_table, wr_index, wr_tag, wr_pred);
            end else begin
               logic [25:0] ew;
               ew = exp_q.pop_front();
               if ({wr_table, wr_index, wr_tag, wr_pred} !== ew) begin
                  bad++;
                  $display("FAIL write_data: got tbl=%0d idx=%0d tag=%h pred=%h required tbl=%0d idx=%0d tag=%h pred=%h",
                           wr_table, wr_index, wr_tag, wr_pred, ew[25], ew[24:22], ew[21:16], ew[15:0]);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Common setup: index_0 = 6, tag_0 = 06, index_1 = 5, tag_1 = 05.
   task automatic set_branch(input logic [15:0] target);
      upd_pc     = 16'h0005;
      upd_h[0]   = 16'h0003;
      upd_h[1]   = 16'h0000;
      upd_target = target;
   endtask

   task automatic set_tables(input logic v0, input logic [5:0] t0, input logic [15:0] p0,
                             input logic v1, input logic [5:0] t1, input logic [15:0] p1);
      cfg_vld[0] = v0; cfg_tag[0] = t0; cfg_pred[0] = p0;
      cfg_vld[1] = v1; cfg_tag[1] = t1; cfg_pred[1] = p1;
   endtask

   task automatic push_reads;
      exp_rd_q.push_back({1'b1, 3'd5});
      exp_rd_q.push_back({1'b0, 3'd6});
   endtask

   // Sends one update from a negedge; returns accept-to-done latency (-1 on
   // timeout) and leaves the bench one cycle after the done pulse.
   task automatic send_update(input logic [15:0] target, output int lat);
      int w;
      set_branch(target);
      upd_valid = 1'b1;
      w = 0;
      while (!upd_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      push_reads();
      @(negedge clk);
      upd_valid = 1'b0;
      lat = 1;
      while (!upd_done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!upd_done) lat = -1;
      @(negedge clk);
   endtask

   task automatic alloc_step;
      if (exp_alloc != CNT_MAX) exp_alloc++;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      total += 7;
      if (upd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b required 1", upd_ready); end
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b required 0", busy); end
      if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %0b required 0", rd_en); end
      if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en: got %0b required 0", wr_en); end
      if (upd_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b required 0", upd_done); end
      if (alloc_cnt !== '0) begin bad++; $display("FAIL reset_alloc: got %0d required 0", alloc_cnt); end
      if ({rd_table, rd_index, wr_table, wr_index, wr_tag, wr_pred} !== '0) begin
         bad++;
         $display("FAIL reset_addr_data: got rd %0d/%0d wr %0d/%0d/%h/%h required all 0",
                  rd_table, rd_index, wr_table, wr_index, wr_tag, wr_pred);
      end
   endtask

   task automatic test_miss_alloc;
      int lat;
      set_tables(1'b0, 6'h06, 16'h0000, 1'b0, 6'h05, 16'h0000);
      exp_q.push_back({1'b0, 3'd6, 6'h06, 16'h1234});
      alloc_step();
      send_update(16'h1234, lat);
      total += 3;
      if (lat !== 4) begin bad++; $display("FAIL miss_latency: got %0d required 4", lat); end
      if (alloc_cnt !== exp_alloc) begin bad++; $display("FAIL miss_alloc: got %0d required %0d", alloc_cnt, exp_alloc); end
      if (exp_q.size() != 0) begin bad++; $display("FAIL miss_write_missing: got %0d pending required 0", exp_q.size()); end
   endtask

   task automatic test_hit1_correct;
      int lat;
      set_tables(1'b0, 6'h00, 16'h0000, 1'b1, 6'h05, 16'h1234);
      send_update(16'h1234, lat);
      total += 2;
      if (lat !== 3) begin bad++; $display("FAIL hit1_ok_latency: got %0d required 3", lat); end
      if (alloc_cnt !== exp_alloc) begin bad++; $display("FAIL hit1_ok_alloc: got %0d required %0d", alloc_cnt, exp_alloc); end
   endtask

   task automatic test_hit1_wrong;
      int lat;
      // Table 0 also hits with a wrong target; table 1 must win.
      set_tables(1'b1, 6'h06, 16'h7777, 1'b1, 6'h05, 16'h1111);
      exp_q.push_back({1'b1, 3'd5, 6'h05, 16'h2222});
      send_update(16'h2222, lat);
      total += 3;
      if (lat !== 4) begin bad++; $display("FAIL hit1_bad_latency: got %0d required 4", lat); end
      if (alloc_cnt !== exp_alloc) begin bad++; $display("FAIL hit1_bad_alloc: got %0d required %0d", alloc_cnt, exp_alloc); end
      if (exp_q.size() != 0) begin bad++; $display("FAIL hit1_bad_write_missing: got %0d pending required 0", exp_q.size()); end
   endtask

   task automatic test_hit0_wrong;
      int lat;
      // Table 1 valid but tag mismatch counts as a miss.
      set_tables(1'b1, 6'h06, 16'h0100, 1'b1, 6'h3f, 16'h0200);
      exp_q.push_back({1'b0, 3'd6, 6'h06, 16'h0200});
      exp_q.push_back({1'b1, 3'd5, 6'h05, 16'h0200});
      alloc_step();
      send_update(16'h0200, lat);
      total += 3;
      if (lat !== 5) begin bad++; $display("FAIL hit0_bad_latency: got %0d required 5", lat); end
      if (alloc_cnt !== exp_alloc) begin bad++; $display("FAIL hit0_bad_alloc: got %0d required %0d", alloc_cnt, exp_alloc); end
      if (exp_q.size() != 0) begin bad++; $display("FAIL hit0_bad_write_missing: got %0d pending required 0", exp_q.size()); end
   endtask

   task automatic test_no_write_cases;
      int lat;
      set_tables(1'b1, 6'h06, 16'h0200, 1'b0, 6'h05, 16'h0200);
      send_update(16'h0200, lat);
      total++;
      if (lat !== 3) begin bad++; $display("FAIL hit0_ok_latency: got %0d required 3", lat); end
      set_tables(1'b0, 6'h06, 16'h0000, 1'b1, 6'h15, 16'h0000);
      send_update(16'h0000, lat);
      total += 2;
      if (lat !== 3) begin bad++; $display("FAIL zero_target_latency: got %0d required 3", lat); end
      if (alloc_cnt !== exp_alloc) begin bad++; $display("FAIL no_write_alloc: got %0d required %0d", alloc_cnt, exp_alloc); end
   endtask

   task automatic test_back_to_back;
      logic [15:0] ta, tb;
      int          lat;
      ta = 16'($urandom_range(1, 16'hffff));
      tb = 16'($urandom_range(1, 16'hffff));
      set_tables(1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000);
      set_branch(ta);
      upd_valid = 1'b1;
      @(posedge clk);
      push_reads();
      exp_q.push_back({1'b0, 3'd6, 6'h06, ta});
      alloc_step();
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         total++;
         if (upd_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_while_busy: got %0b required 0", upd_ready); end
      end while (!upd_done && lat < 20);
      total++;
      if (lat !== 4) begin bad++; $display("FAIL b2b_first_latency: got %0d required 4", lat); end
      upd_target = tb;
      @(negedge clk);
      total++;
      if (upd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_done: got %0b required 1", upd_ready); end
      @(posedge clk);
      push_reads();
      exp_q.push_back({1'b0, 3'd6, 6'h06, tb});
      alloc_step();
      @(negedge clk);
      upd_valid = 1'b0;
      lat = 1;
      while (!upd_done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      @(negedge clk);
      total += 3;
      if (lat !== 4) begin bad++; $display("FAIL b2b_second_latency: got %0d required 4", lat); end
      if (alloc_cnt !== exp_alloc) begin bad++; $display("FAIL b2b_alloc: got %0d required %0d", alloc_cnt, exp_alloc); end
      if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_write_missing: got %0d pending required 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid_write;
      int w;
      set_tables(1'b1, 6'h06, 16'h0100, 1'b0, 6'h05, 16'h0000);
      set_branch(16'h0300);
      upd_valid = 1'b1;
      @(posedge clk);
      push_reads();
      // Only the WRA write is expected; a WRB write would be unexpected.
      exp_q.push_back({1'b0, 3'd6, 6'h06, 16'h0300});
      @(negedge clk);
      upd_valid = 1'b0;
      w = 1;
      while (!wr_en && w < 20) begin
         @(negedge clk);
         w++;
      end
      total++;
      if (w !== 4) begin bad++; $display("FAIL rstmid_wra_cycle: got %0d required 4", w); end
      #2;
      rst = 1'b1;
      exp_alloc = '0;
      @(negedge clk);
      total += 3;
      if (wr_en !== 1'b0) begin bad++; $display("FAIL rstmid_wr_en: got %0b required 0", wr_en); end
      if (wr_pred !== 16'h0000) begin bad++; $display("FAIL rstmid_wr_pred: got %h required 0000", wr_pred); end
      if (alloc_cnt !== '0) begin bad++; $display("FAIL rstmid_alloc: got %0d required 0", alloc_cnt); end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total += 3;
         if (upd_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %0b required 1", upd_ready); end
         if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %0b required 0", busy); end
         if (wr_en !== 1'b0) begin bad++; $display("FAIL rstmid_no_wrb: got %0b required 0", wr_en); end
      end
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL rstmid_wra_missing: got %0d pending required 0", exp_q.size()); end
   endtask

   task automatic test_alloc_saturate;
      int          lat;
      logic [15:0] t;
      set_tables(1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000);
      for (int n = 0; n < 15; n++) begin
         t = 16'($urandom_range(1, 16'hffff));
         exp_q.push_back({1'b0, 3'd6, 6'h06, t});
         alloc_step();
         send_update(t, lat);
      end
      total++;
      if (alloc_cnt !== CNT_MAX) begin bad++; $display("FAIL sat_reach: got %0d required %0d", alloc_cnt, CNT_MAX); end
      exp_q.push_back({1'b0, 3'd6, 6'h06, 16'hbeef});
      alloc_step();
      send_update(16'hbeef, lat);
      total += 3;
      if (lat !== 4) begin bad++; $display("FAIL sat_latency: got %0d required 4", lat); end
      if (alloc_cnt !== exp_alloc) begin bad++; $display("FAIL sat_hold: got %0d required %0d", alloc_cnt, exp_alloc); end
      if (exp_q.size() != 0) begin bad++; $display("FAIL sat_write_missing: got %0d pending required 0", exp_q.size()); end
   endtask

   // ---------------- sequence ----------------
   initial begin
      set_tables(1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000);
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_miss_alloc();
      test_hit1_correct();
      test_hit1_wrong();
      test_hit0_wrong();
      test_no_write_cases();
      test_back_to_back();
      test_reset_mid_write();
      test_alloc_saturate();
      total++;
      if (exp_rd_q.size() != 0) begin bad++; $display("FAIL reads_missing: got %0d pending required 0", exp_rd_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
